// File: rtl/f7_pkg.sv
// ---------------------------------------------------------------------------
// f7_pkg
// Shared definitions for the OR/NOR select-gate sequencer and its golden
// reference:
//   f7_state_e   - sequencer state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3)
//   F7_EXPECTED  - expected gate output, bit i for operand index i = {x,y,sel}
//   F7_NVEC      - number of operand vectors in one run
//   f7_golden()  - golden gate function: sel=0 -> x|y, sel=1 -> ~(x|y)
// ---------------------------------------------------------------------------
package f7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } f7_state_e;

  localparam logic [7:0] F7_EXPECTED = 8'h56;
  localparam int         F7_NVEC     = 8;

  function automatic logic f7_golden(input logic x, input logic y, input logic sel);
    return sel ? ~(x | y) : (x | y);
  endfunction

endpackage

// File: rtl/f7_golden_ref.sv
// ---------------------------------------------------------------------------
// f7_golden_ref
// Combinational golden model of the OR/NOR select gate stage.
// Ports:
//   x_i, y_i  - operands
//   sel_i     - function select (0: OR, 1: NOR)
//   exp_o     - expected gate output
// ---------------------------------------------------------------------------
module f7_golden_ref
  import f7_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  input  logic sel_i,
  output logic exp_o
);

  assign exp_o = f7_golden(x_i, y_i, sel_i);

endmodule

// File: rtl/f7_sel_sequencer.sv
// ---------------------------------------------------------------------------
// f7_sel_sequencer
// Drives all eight {x, y, sel} operand combinations into the OR/NOR select
// gate stage, waits SETTLE cycles per vector, samples the returned bit and
// compares it with the golden function.
// Parameters:
//   SETTLE - cycles operands are held before sampling s_in (1..15)
//   ERR_W  - width of the saturating mismatch counter
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a run (honoured only in IDLE or DONE)
//   x, y, sel   - registered operands to the gate stage ({x,y,sel} = idx)
//   s_in        - result returned by the gate stage
//   busy        - run in progress (DRIVE or SAMPLE)
//   done        - run finished; held until the next start
//   result_vec  - bit i = s_in captured for vector i
//   err_cnt     - mismatches in the current run (saturating)
//   pass        - done with zero mismatches
// ---------------------------------------------------------------------------
module f7_sel_sequencer
  import f7_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             x,
  output logic             y,
  output logic             sel,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result_vec,
  output logic [ERR_W-1:0] err_cnt,
  output logic             pass
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  f7_state_e        state_q, state_d;
  logic [2:0]       idx_q,   idx_d;
  logic [3:0]       cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [7:0]       res_q,   res_d;
  logic [ERR_W-1:0] err_q,   err_d;
  logic             exp_bit;

  // Operands are held in op_q, which equals idx_q during SAMPLE, so the
  // golden reference sees exactly what the gate stage is being driven with.
  f7_golden_ref u_golden (
    .x_i   (op_q[2]),
    .y_i   (op_q[1]),
    .sel_i (op_q[0]),
    .exp_o (exp_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          res_d   = '0;
          err_d   = '0;
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        res_d[idx_q] = s_in;
        if ((s_in != exp_bit) && (err_q != ERR_MAX)) begin
          err_d = err_q + 1'b1;
        end
        if (idx_q == 3'(F7_NVEC - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status and operands are registered from the next state so the
    // outputs never see decode glitches.
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    op_d   = busy_d ? idx_d : 3'd0;
  end

  assign {x, y, sel} = op_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result_vec  = res_q;
  assign err_cnt     = err_q;
  assign pass        = done_q && (err_q == '0);

endmodule

// File: tb/tb_f7_sel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_f7_sel_sequencer
// Directed bench: one sequencer with SETTLE=1 driving a selectable gate model
// (correct OR/NOR, stuck-at-0, stuck-at-1, AND/NAND), and one with SETTLE=3
// driving a correct gate.
// ---------------------------------------------------------------------------
module tb_f7_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start3;
  int         mode;

  logic       x1, y1, sel1, s_in1, busy1, done1, pass1;
  logic [7:0] res1;
  logic [3:0] err1;

  logic       x3, y3, sel3, s_in3, busy3, done3, pass3;
  logic [7:0] res3;
  logic [3:0] err3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Gate stage model for the SETTLE=1 instance
  always_comb begin
    s_in1 = 1'b0;
    case (mode)
      0:       s_in1 = sel1 ? ~(x1 | y1) : (x1 | y1);
      1:       s_in1 = 1'b0;
      2:       s_in1 = 1'b1;
      default: s_in1 = sel1 ? ~(x1 & y1) : (x1 & y1);
    endcase
  end

  assign s_in3 = sel3 ? ~(x3 | y3) : (x3 | y3);

  f7_sel_sequencer #(.SETTLE(1), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .x(x1), .y(y1), .sel(sel1), .s_in(s_in1),
    .busy(busy1), .done(done1), .result_vec(res1), .err_cnt(err1), .pass(pass1)
  );

  f7_sel_sequencer #(.SETTLE(3), .ERR_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .x(x3), .y(y3), .sel(sel3), .s_in(s_in3),
    .busy(busy3), .done(done3), .result_vec(res3), .err_cnt(err3), .pass(pass3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the edge that samples start (edge 0)
  task automatic start_dut1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  // Continues counting edges from 'from' until done1, bounded
  task automatic wait_done1(input int from, output int edges);
    edges = from;
    while (done1 !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic report1(input string name, input int edges);
    $display("run %s: edges=%0d result_vec=%02h err_cnt=%0d pass=%0b",
             name, edges, res1, err1, pass1);
  endtask

  initial begin
    int edges;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mode   = 0;

    // Reset state
    repeat (2) tick();
    check("rst_busy",   busy1, 0);
    check("rst_done",   done1, 0);
    check("rst_op",     {x1, y1, sel1}, 0);
    check("rst_result", res1, 0);
    check("rst_err",    err1, 0);
    check("rst_pass",   pass1, 0);
    check("rst_done3",  done3, 0);
    rst_n = 1'b1;
    tick();

    // 1: correct gate, operand stepping and 16-edge latency
    start_dut1();
    for (int k = 0; k < 16; k++) begin
      check("t1_busy", busy1, 1);
      check("t1_done_low", done1, 0);
      if (k % 2 == 0) check("t1_op", {x1, y1, sel1}, k / 2);
      tick();
    end
    check("t1_done",   done1, 1);
    check("t1_busy_end", busy1, 0);
    check("t1_op_idle", {x1, y1, sel1}, 0);
    check("t1_result", res1, 8'h56);
    check("t1_err",    err1, 0);
    check("t1_pass",   pass1, 1);
    report1("t1_correct", 16);

    // 2: stuck-at-0 / stuck-at-1 gate
    mode = 1;
    start_dut1();
    wait_done1(0, edges);
    check("t2a_edges",  edges, 16);
    check("t2a_result", res1, 8'h00);
    check("t2a_err",    err1, 4);
    check("t2a_pass",   pass1, 0);
    report1("t2_tie0", edges);

    mode = 2;
    start_dut1();
    wait_done1(0, edges);
    check("t2b_edges",  edges, 16);
    check("t2b_result", res1, 8'hFF);
    check("t2b_err",    err1, 4);
    check("t2b_pass",   pass1, 0);
    report1("t2_tie1", edges);

    // 3: AND/NAND gate in place of OR/NOR
    mode = 3;
    start_dut1();
    wait_done1(0, edges);
    check("t3_result", res1, 8'h6A);
    check("t3_err",    err1, 4);
    check("t3_pass",   pass1, 0);
    report1("t3_andnand", edges);

    // 4: reset mid-run at idx 3 in DRIVE
    mode = 0;
    start_dut1();
    repeat (6) tick();
    check("t4_pre_op",   {x1, y1, sel1}, 3);
    check("t4_pre_busy", busy1, 1);
    rst_n = 1'b0;
    #2;
    check("t4_rst_op",     {x1, y1, sel1}, 0);
    check("t4_rst_busy",   busy1, 0);
    check("t4_rst_done",   done1, 0);
    check("t4_rst_result", res1, 0);
    check("t4_rst_err",    err1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_idle_busy", busy1, 0);
    start_dut1();
    wait_done1(0, edges);
    check("t4_edges",  edges, 16);
    check("t4_result", res1, 8'h56);
    check("t4_pass",   pass1, 1);
    report1("t4_after_reset", edges);

    // 5: start held and re-pulsed during a run; then restart from DONE
    mode = 3;
    start1 = 1'b1;
    tick();
    repeat (4) tick();
    start1 = 1'b0;
    repeat (6) tick();
    check("t5_idx5", {x1, y1, sel1}, 5);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done1(11, edges);
    check("t5_edges",  edges, 16);
    check("t5_result", res1, 8'h6A);
    check("t5_err",    err1, 4);
    report1("t5_held_start", edges);

    mode = 0;
    start_dut1();
    check("t5_done_drop", done1, 0);
    check("t5_busy_rise", busy1, 1);
    check("t5_err_clear", err1, 0);
    wait_done1(0, edges);
    check("t5_edges2",  edges, 16);
    check("t5_result2", res1, 8'h56);
    check("t5_err2",    err1, 0);
    check("t5_pass2",   pass1, 1);
    report1("t5_restart", edges);

    // 6: SETTLE=3 instance
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    edges = 0;
    while (done3 !== 1'b1 && edges < 200) begin
      if (edges % 4 != 3) check("t6_op", {x3, y3, sel3}, edges / 4);
      tick();
      edges++;
    end
    check("t6_edges",  edges, 32);
    check("t6_result", res3, 8'h56);
    check("t6_err",    err3, 0);
    check("t6_pass",   pass3, 1);
    $display("run t6_settle3: edges=%0d result_vec=%02h err_cnt=%0d pass=%0b",
             edges, res3, err3, pass3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
